// File: rtl/pc_seq_pkg.sv
// +--------------------------------------------------------------------+
// | pc_seq_pkg : shared state encoding and constants for pc_sequencer   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package pc_seq_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef logic [STATE_W-1:0] pc_seq_state_t;

  localparam pc_seq_state_t ST_BOOT     = 3'd0;
  localparam pc_seq_state_t ST_FETCH    = 3'd1;
  localparam pc_seq_state_t ST_ADVANCE  = 3'd2;
  localparam pc_seq_state_t ST_HOLD     = 3'd3;
  localparam pc_seq_state_t ST_REDIRECT = 3'd4;
  localparam pc_seq_state_t ST_HALTED   = 3'd5;

  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0010;

  // program_counter.sel encodings
  localparam logic PC_SEL_INC  = 1'b0;
  localparam logic PC_SEL_LOAD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_fetch_timeout_counter.sv
// +--------------------------------------------------------------------+
// | fetch_timeout_counter : counts non-ready fetch cycles, pulses       |
// | expire on the TIMEOUT-th one. Rev 1.0                               |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_timeout_counter
  import pc_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic expire
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (incr) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Counts prior misses, so the current miss is the TIMEOUT-th when count is TIMEOUT-1
  assign expire = incr && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +--------------------------------------------------------------------+
// | pc_sequencer : fetch-side PC controller. Optional trap support is   |
// | enabled by defining PC_SEQ_TRAP_EN. Rev 1.0                         |
// +--------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
`ifdef PC_SEQ_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap_req,
  output logic [31:0] trap_epc,
`endif
  output logic        pc_enable,
  output logic        pc_sel,
  output logic [31:0] pc_data,
  output logic        fetch_valid,
  output logic        fetch_fault
);

  pc_seq_state_t r_state;
  pc_seq_state_t w_next;
  logic [31:0]   r_redirect;
  logic [31:0]   w_redirect_val;
  logic          w_load;
  logic          w_expire;
  logic          w_kill;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state != ST_FETCH),
    .incr   ((r_state == ST_FETCH) && !imem_ready),
    .expire (w_expire)
  );

`ifdef PC_SEQ_TRAP_EN
  logic        w_trap;
  logic [31:0] r_epc;

  assign w_trap   = trap_req || w_expire;
  assign w_kill   = branch_taken || halt || trap_req;
  assign trap_epc = r_epc;
`else
  logic w_unused_pc;

  // pc is only consumed by the trap logic
  assign w_unused_pc = ^pc;
  assign w_kill      = branch_taken || halt;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_redirect <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_redirect <= w_redirect_val;
      end
    end
  end

`ifdef PC_SEQ_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_epc <= '0;
    end else if (!halt && w_trap &&
                 ((r_state == ST_FETCH) || (r_state == ST_HOLD) || (r_state == ST_ADVANCE))) begin
      r_epc <= pc;
    end
  end
`endif

  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_redirect_val = r_redirect;
    case (r_state)
      ST_BOOT:     w_next = ST_FETCH;
      ST_REDIRECT: w_next = ST_FETCH;
      ST_HALTED:   w_next = ST_HALTED;
      ST_FETCH, ST_HOLD, ST_ADVANCE: begin
        if (halt) begin
          w_next = ST_HALTED;
`ifdef PC_SEQ_TRAP_EN
        end else if (w_trap) begin
          w_next         = ST_REDIRECT;
          w_load         = 1'b1;
          w_redirect_val = TRAP_VECTOR;
`else
        end else if (w_expire) begin
          w_next = ST_HALTED;
`endif
        end else if (branch_taken) begin
          w_next         = ST_REDIRECT;
          w_load         = 1'b1;
          w_redirect_val = branch_target;
        end else if (r_state == ST_FETCH) begin
          if (imem_ready) begin
            w_next = stall ? ST_HOLD : ST_ADVANCE;
          end
        end else if (r_state == ST_HOLD) begin
          if (!stall) begin
            w_next = ST_ADVANCE;
          end
        end else begin
          w_next = ST_FETCH;
        end
      end
      default:     w_next = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    pc_enable   = 1'b0;
    pc_sel      = PC_SEL_INC;
    pc_data     = '0;
    fetch_valid = 1'b0;
    case (r_state)
      ST_FETCH:    imem_req = 1'b1;
      ST_ADVANCE: begin
        pc_enable   = 1'b1;
        fetch_valid = !w_kill;
      end
      ST_REDIRECT: begin
        pc_enable = 1'b1;
        pc_sel    = PC_SEL_LOAD;
        pc_data   = r_redirect;
      end
      default: ;
    endcase
  end

  // Ready in the same cycle suppresses incr, so no fault can be raised then
  assign fetch_fault = w_expire;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_pc_sequencer : self-checking bench with a PC register and a      |
// | behavioural reference model of the fetch sequencer. Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

  localparam int          TMO = 4;
  localparam logic [31:0] TV  = 32'h0000_0010;

  localparam int P_BOOT = 0, P_FETCH = 1, P_ADV = 2, P_HOLD = 3, P_RED = 4, P_HALT = 5;

  logic        clock, reset;
  logic [31:0] pc;
  logic        imem_req, imem_ready, stall, branch_taken, halt;
  logic [31:0] branch_target;
  logic        pc_enable, pc_sel, fetch_valid, fetch_fault;
  logic [31:0] pc_data;
  logic        trap_req;
  logic [31:0] trap_epc;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_ph;
  int          m_cnt;
  logic [31:0] m_pc, m_redir, m_epc;

  pc_sequencer #(
    .TIMEOUT       (TMO)
`ifdef PC_SEQ_TRAP_EN
    , .TRAP_VECTOR (TV)
`endif
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc            (pc),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
`ifdef PC_SEQ_TRAP_EN
    .trap_req      (trap_req),
    .trap_epc      (trap_epc),
`endif
    .pc_enable     (pc_enable),
    .pc_sel        (pc_sel),
    .pc_data       (pc_data),
    .fetch_valid   (fetch_valid),
    .fetch_fault   (fetch_fault)
  );

`ifndef PC_SEQ_TRAP_EN
  assign trap_epc = 32'h0;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph    = P_BOOT;
    m_cnt   = 0;
    m_pc    = 32'h0;
    m_redir = 32'h0;
    m_epc   = 32'h0;
  endtask

  // Asserts reset mid-cycle; outputs must fall before any clock edge
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    pc    = 32'h0;
    #1;
    chk("rst_imem_req",    imem_req,    32'h0);
    chk("rst_pc_enable",   pc_enable,   32'h0);
    chk("rst_pc_sel",      pc_sel,      32'h0);
    chk("rst_pc_data",     pc_data,     32'h0);
    chk("rst_fetch_valid", fetch_valid, 32'h0);
    chk("rst_fetch_fault", fetch_fault, 32'h0);
`ifdef PC_SEQ_TRAP_EN
    chk("rst_trap_epc",    trap_epc,    32'h0);
`endif
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock: apply inputs, compare against the model, then advance both
  task automatic step(input bit rdy, input bit stl, input bit br, input bit hlt,
                      input bit trp, input logic [31:0] tgt);
    bit          e_fault, trap_in, trap_now;
    logic        en_c, sel_c;
    logic [31:0] data_c, nxt_pc;
    int          nph;
    @(negedge clock);
    imem_ready    = rdy;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hlt;
`ifdef PC_SEQ_TRAP_EN
    trap_req = trp;
    trap_in  = trp;
`else
    trap_req = 1'b0;
    trap_in  = 1'b0;
`endif
    #1;
    e_fault = (m_ph == P_FETCH) && !rdy && (m_cnt + 1 == TMO);
`ifdef PC_SEQ_TRAP_EN
    trap_now = trap_in || e_fault;
`else
    trap_now = 1'b0;
`endif
    chk("imem_req",    imem_req,    {31'b0, m_ph == P_FETCH});
    chk("pc_enable",   pc_enable,   {31'b0, (m_ph == P_ADV) || (m_ph == P_RED)});
    chk("pc_sel",      pc_sel,      {31'b0, m_ph == P_RED});
    chk("pc_data",     pc_data,     (m_ph == P_RED) ? m_redir : 32'h0);
    chk("fetch_valid", fetch_valid, {31'b0, (m_ph == P_ADV) && !(br || hlt || trap_in)});
    chk("fetch_fault", fetch_fault, {31'b0, e_fault});
    chk("pc",          pc,          m_pc);
`ifdef PC_SEQ_TRAP_EN
    chk("trap_epc",    trap_epc,    m_epc);
`endif
    en_c   = pc_enable;
    sel_c  = pc_sel;
    data_c = pc_data;

    nxt_pc = m_pc;
    if (m_ph == P_ADV) nxt_pc = m_pc + 1;
    if (m_ph == P_RED) nxt_pc = m_redir;

    nph = m_ph;
    if (m_ph == P_BOOT || m_ph == P_RED) begin
      nph = P_FETCH;
    end else if (m_ph != P_HALT) begin
      if (hlt) begin
        nph = P_HALT;
      end else if (trap_now) begin
        nph     = P_RED;
        m_redir = TV;
        m_epc   = m_pc;
      end else if (e_fault) begin
        nph = P_HALT;
      end else if (br) begin
        nph     = P_RED;
        m_redir = tgt;
      end else if (m_ph == P_FETCH) begin
        if (rdy) nph = stl ? P_HOLD : P_ADV;
      end else if (m_ph == P_HOLD) begin
        if (!stl) nph = P_ADV;
      end else begin
        nph = P_FETCH;
      end
    end
    m_cnt = (m_ph == P_FETCH && nph == P_FETCH && !rdy) ? m_cnt + 1 : 0;

    @(posedge clock);
    #1;
    if (en_c) pc = sel_c ? data_c : pc + 1;
    m_ph = nph;
    m_pc = nxt_pc;
  endtask

  initial begin
    reset         = 1'b1;
    pc            = 32'h0;
    imem_ready    = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    halt          = 1'b0;
    trap_req      = 1'b0;
    model_reset();
    do_reset();

    // zero-wait streaming: pc advances every 2 cycles
    repeat (8) step(1, 0, 0, 0, 0, 32'h0);

    // stall after ready parks the sequencer in HOLD
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 0, 0, 0, 32'h0);
    repeat (3) step(0, 1, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);

    // branch during ADVANCE at pc=5
    for (int i = 0; i < 20 && !(m_ph == P_ADV && m_pc == 32'd5); i++)
      step(1, 0, 0, 0, 0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h40);
    repeat (3) step(1, 0, 0, 0, 0, 32'h0);

    // instruction memory never ready: timeout
    repeat (8) step(0, 0, 0, 0, 0, 32'h0);
    do_reset();

    // halt beats branch; later branches are ignored
    repeat (3) step(1, 0, 0, 0, 0, 32'h0);
    step(1, 0, 1, 1, 0, 32'h80);
    repeat (3) step(1, 0, 1, 0, 0, 32'h90);
    do_reset();

    // reset while REDIRECT is in flight
    repeat (2) step(1, 0, 0, 0, 0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h20);
    do_reset();
    repeat (4) step(1, 0, 0, 0, 0, 32'h0);

    // randomized traffic with slow-memory phases
    for (int i = 0; i < 500; i++) begin
      bit slow;
      slow = ((i / 32) % 2) == 1;
      if (m_ph == P_HALT && ($urandom % 4) == 0) begin
        do_reset();
      end else begin
        step(($urandom % 10) < (slow ? 3 : 8),
             ($urandom % 10) < 3,
             ($urandom % 12) == 0,
             ($urandom % 80) == 0,
             ($urandom % 30) == 0,
             $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
